// File: rtl/pipe_elastic.sv
// Elastic pipeline register: a chain of STAGES two-entry skid slices with
// valid/ready handshaking and a synchronous flush. Each slice's upstream ready
// depends only on its own skid flop, so ready never ripples combinationally
// across the chain.
module pipe_elastic #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int CW     = $clog2(2*STAGES+1)
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InData,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutData,
    output logic [CW-1:0]    Occupancy
);

    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0] mv_q, mv_d;
    logic [STAGES-1:0] sv_q, sv_d;
    logic [WIDTH-1:0]  md_q [STAGES];
    logic [WIDTH-1:0]  md_d [STAGES];
    logic [WIDTH-1:0]  sd_q [STAGES];
    logic [WIDTH-1:0]  sd_d [STAGES];
    logic [CW-1:0]     occ_q, occ_d;

    logic [STAGES-1:0] up_valid;
    logic [STAGES-1:0] ds_ready;
    logic [STAGES-1:0] acc;
    logic [STAGES-1:0] take;
    logic [WIDTH-1:0]  up_data [STAGES];

    // Slice interconnect: each slice feeds from its predecessor's main register
    // and sees its successor's skid-empty flag as downstream ready.
    for (genvar i = 0; i < STAGES; i++) begin : g_link
        if (i == 0) begin : g_head
            assign up_valid[i] = InValid;
            assign up_data[i]  = InData;
        end else begin : g_body
            assign up_valid[i] = mv_q[i-1];
            assign up_data[i]  = md_q[i-1];
        end
        if (i == LAST) begin : g_tail
            assign ds_ready[i] = OutReady;
        end else begin : g_mid
            assign ds_ready[i] = ~sv_q[i+1];
        end
        assign acc[i]  = up_valid[i] & ~sv_q[i];
        assign take[i] = mv_q[i] & ds_ready[i];
    end

    // Next-state for every slice's main/skid registers; flush clears valids only.
    always_comb begin
        mv_d = mv_q;
        sv_d = sv_q;
        for (int i = 0; i < STAGES; i++) begin
            md_d[i] = md_q[i];
            sd_d[i] = sd_q[i];
        end
        for (int i = 0; i < STAGES; i++) begin
            if (Flush) begin
                mv_d[i] = 1'b0;
                sv_d[i] = 1'b0;
            end else if (take[i]) begin
                if (sv_q[i]) begin
                    md_d[i] = sd_q[i];
                    if (acc[i]) begin
                        sd_d[i] = up_data[i];
                    end else begin
                        sv_d[i] = 1'b0;
                    end
                end else begin
                    if (acc[i]) begin
                        md_d[i] = up_data[i];
                    end else begin
                        mv_d[i] = 1'b0;
                    end
                end
            end else if (acc[i]) begin
                if (!mv_q[i]) begin
                    md_d[i] = up_data[i];
                    mv_d[i] = 1'b1;
                end else begin
                    sd_d[i] = up_data[i];
                    sv_d[i] = 1'b1;
                end
            end
        end
    end

    // Occupancy tracked as a counter so the output comes straight from a flop.
    always_comb begin
        occ_d = occ_q;
        if (Flush) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + CW'(acc[0]) - CW'(take[LAST]);
        end
    end

    // State registers; reset empties the chain and zeroes the payload.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            mv_q  <= '0;
            sv_q  <= '0;
            occ_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                md_q[i] <= '0;
                sd_q[i] <= '0;
            end
        end else begin
            mv_q  <= mv_d;
            sv_q  <= sv_d;
            occ_q <= occ_d;
            for (int i = 0; i < STAGES; i++) begin
                md_q[i] <= md_d[i];
                sd_q[i] <= sd_d[i];
            end
        end
    end

    assign InReady   = ~sv_q[0];
    assign OutValid  = mv_q[LAST];
    assign OutData   = md_q[LAST];
    assign Occupancy = occ_q;

endmodule

// File: tb/tb_pipe_elastic.sv
// Directed bench for pipe_elastic: a STAGES=2/WIDTH=32 instance with a
// scoreboard for ordering and occupancy, and a STAGES=1/WIDTH=1 instance.
module tb_pipe_elastic;

    logic        Clock;
    logic        nReset;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [2:0]  a_occ;

    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [0:0]  b_in_data, b_out_data;
    logic [1:0]  b_occ;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb_q[$];
    int          a_occ_m  = 0;
    logic        last_acc = 1'b0;
    logic        last_emit = 1'b0;

    pipe_elastic #(.WIDTH(32), .STAGES(2)) u_a (
        .Clock    (Clock),
        .nReset   (nReset),
        .Flush    (a_flush),
        .InValid  (a_in_valid),
        .InReady  (a_in_ready),
        .InData   (a_in_data),
        .OutValid (a_out_valid),
        .OutReady (a_out_ready),
        .OutData  (a_out_data),
        .Occupancy(a_occ)
    );

    pipe_elastic #(.WIDTH(1), .STAGES(1)) u_b (
        .Clock    (Clock),
        .nReset   (nReset),
        .Flush    (b_flush),
        .InValid  (b_in_valid),
        .InReady  (b_in_ready),
        .InData   (b_in_data),
        .OutValid (b_out_valid),
        .OutReady (b_out_ready),
        .OutData  (b_out_data),
        .Occupancy(b_occ)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // One edge of instance A with scoreboard bookkeeping of the handshakes.
    task automatic a_step();
        logic        acc, emit, fl;
        logic [31:0] din, dout, exp;
        acc  = a_in_valid && a_in_ready;
        emit = a_out_valid && a_out_ready;
        fl   = a_flush;
        din  = a_in_data;
        dout = a_out_data;
        tick();
        last_acc  = acc && !fl;
        last_emit = emit && !fl;
        if (fl) begin
            sb_q.delete();
            a_occ_m = 0;
        end else begin
            if (emit) begin
                checks++;
                assert (sb_q.size() != 0) else begin
                    errors++;
                    $error("FAIL order_extra observed=%h expected=none", dout);
                end
                if (sb_q.size() != 0) begin
                    exp = sb_q.pop_front();
                    chk("order", dout, exp);
                end
            end
            if (acc) sb_q.push_back(din);
            a_occ_m = a_occ_m + int'(acc) - int'(emit);
        end
        chk("occupancy", 32'(a_occ), 32'(a_occ_m));
    endtask

    initial begin
        int next;
        int sent;
        int rcvd;
        int cyc;

        nReset      = 1'b0;
        a_flush     = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_flush     = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
        #3;
        chk("rst_in_ready",  32'(a_in_ready),  32'd1);
        chk("rst_out_valid", 32'(a_out_valid), 32'd0);
        chk("rst_out_data",  a_out_data,       32'd0);
        chk("rst_occ",       32'(a_occ),       32'd0);
        chk("rst_b_ready",   32'(b_in_ready),  32'd1);
        #4 nReset = 1'b1;
        tick();

        // Latency into an empty chain
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_data   = 32'hA5A5_0001;
        a_step();
        a_in_valid  = 1'b0;
        chk("lat_valid0", 32'(a_out_valid), 32'd0);
        chk("lat_occ0",   32'(a_occ),       32'd1);
        a_step();
        chk("lat_valid1", 32'(a_out_valid), 32'd1);
        chk("lat_data1",  a_out_data,       32'hA5A5_0001);
        chk("lat_occ1",   32'(a_occ),       32'd1);
        a_step();
        chk("lat_valid2", 32'(a_out_valid), 32'd0);
        chk("lat_occ2",   32'(a_occ),       32'd0);

        // Back-pressure: only four of six entries fit
        a_out_ready = 1'b0;
        next = 1;
        for (int k = 0; k < 5; k++) begin
            a_in_valid = 1'b1;
            a_in_data  = 32'(next);
            a_step();
            if (last_acc) next++;
        end
        chk("bp_accepted", 32'(next - 1),     32'd4);
        chk("bp_occ_full", 32'(a_occ),        32'd4);
        chk("bp_in_ready", 32'(a_in_ready),   32'd0);
        chk("bp_head",     a_out_data,        32'd1);
        a_out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            a_in_valid = (next <= 6);
            a_in_data  = 32'(next);
            a_step();
            if (last_acc) next++;
            chk("bp_valid", 32'(a_out_valid), 32'(k < 5));
            if (k < 5) chk("bp_data", a_out_data, 32'(k + 2));
        end
        chk("bp_all_in", 32'(next), 32'd7);
        a_in_valid = 1'b0;

        // Streaming with random downstream stalls
        sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < 1000 && cyc < 6000) begin
            a_out_ready = 1'($urandom_range(0, 1));
            a_in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            a_in_data   = 32'h0001_0000 + 32'(sent);
            a_step();
            if (last_acc)  sent++;
            if (last_emit) rcvd++;
            cyc++;
            checks++;
            assert (a_occ <= 3'd4) else begin
                errors++;
                $error("FAIL stream_occ_max observed=%0d expected<=4", a_occ);
            end
        end
        chk("stream_received", 32'(rcvd), 32'd1000);
        chk("stream_sb_empty", 32'(sb_q.size()), 32'd0);
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;

        // Flush with a full chain, simultaneous accept attempt and emit
        for (int k = 0; k < 4; k++) begin
            a_in_valid = 1'b1;
            a_in_data  = 32'h11 + 32'(k);
            a_step();
        end
        chk("fl_occ_full", 32'(a_occ), 32'd4);
        a_flush     = 1'b1;
        a_in_valid  = 1'b1;
        a_in_data   = 32'h0000_DEAD;
        a_out_ready = 1'b1;
        a_step();
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        chk("fl_occ",       32'(a_occ),       32'd0);
        chk("fl_out_valid", 32'(a_out_valid), 32'd0);
        chk("fl_in_ready",  32'(a_in_ready),  32'd1);
        for (int k = 0; k < 3; k++) begin
            a_step();
            chk("fl_no_dead", 32'(a_out_valid), 32'd0);
        end

        // Asynchronous reset with three entries held
        a_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a_in_valid = 1'b1;
            a_in_data  = 32'h31 + 32'(k);
            a_step();
        end
        a_in_valid = 1'b0;
        chk("mr_occ_pre", 32'(a_occ), 32'd3);
        #2 nReset = 1'b0;
        #1;
        chk("mr_in_ready",  32'(a_in_ready),  32'd1);
        chk("mr_out_valid", 32'(a_out_valid), 32'd0);
        chk("mr_out_data",  a_out_data,       32'd0);
        chk("mr_occ",       32'(a_occ),       32'd0);
        sb_q.delete();
        a_occ_m = 0;
        #1 nReset = 1'b1;
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_data   = 32'h7;
        a_step();
        a_in_valid = 1'b0;
        chk("mr_lat0", 32'(a_out_valid), 32'd0);
        a_step();
        chk("mr_lat1_valid", 32'(a_out_valid), 32'd1);
        chk("mr_lat1_data",  a_out_data,       32'h7);

        // Degenerate single slice, one-bit payload
        b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = 1'b1;
        tick();
        chk("b1_valid", 32'(b_out_valid), 32'd1);
        chk("b1_data",  32'(b_out_data),  32'd1);
        chk("b1_ready", 32'(b_in_ready),  32'd1);
        b_in_data = 1'b0;
        tick();
        chk("b2_occ",   32'(b_occ),       32'd2);
        chk("b2_ready", 32'(b_in_ready),  32'd0);
        chk("b2_data",  32'(b_out_data),  32'd1);
        b_out_ready = 1'b1; b_in_data = 1'b1;
        tick();
        chk("b3_data",  32'(b_out_data),  32'd0);
        chk("b3_occ",   32'(b_occ),       32'd1);
        chk("b3_ready", 32'(b_in_ready),  32'd1);
        b_out_ready = 1'b0;
        tick();
        chk("b4_occ",   32'(b_occ),       32'd2);
        chk("b4_ready", 32'(b_in_ready),  32'd0);
        chk("b4_data",  32'(b_out_data),  32'd0);
        b_out_ready = 1'b1; b_in_valid = 1'b0;
        tick();
        chk("b5_data",  32'(b_out_data),  32'd1);
        chk("b5_occ",   32'(b_occ),       32'd1);
        b_out_ready = 1'b0;
        tick();
        chk("b6_occ",   32'(b_occ),       32'd1);
        b_out_ready = 1'b1;
        tick();
        chk("b7_valid", 32'(b_out_valid), 32'd0);
        chk("b7_occ",   32'(b_occ),       32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_elastic.md
Name: pipe_elastic

Overview:
Parametrised successor to the fixed inter-stage pipeline register. It is an elastic chain of STAGES register slices carrying a WIDTH-bit payload, with valid/ready handshaking and synchronous flush. Each slice is a 2-entry skid buffer, so back-pressure never needs a combinational ready path across the chain. It sits between processor pipeline stages (IF/DEC, DEC/EX, EX/MEM, MEM/WB) and replaces the always-advancing register, so a stage can stall or be squashed on a taken branch.

Parameters:
WIDTH, 32, payload width in bits; must be >= 1.
STAGES, 2, number of cascaded skid slices; must be >= 1. Capacity is 2*STAGES entries.
CW, $clog2(2*STAGES+1), width of the Occupancy output (derived; do not override).

Ports:
Clock  input  1  rising-edge clock; the only clock.
nReset  input  1  asynchronous, active-low reset.
Flush  input  1  synchronous squash of every held entry.
InValid  input  1  upstream presents InData.
InReady  output  1  block can accept; registered.
InData  input  WIDTH  upstream payload.
OutValid  output  1  OutData holds a valid entry; registered.
OutReady  input  1  downstream accepts this cycle.
OutData  output  WIDTH  payload of the oldest entry; registered.
Occupancy  output  CW  number of valid entries held (0..2*STAGES); registered.

Behaviour:
- Reset (nReset=0, asynchronous): all main/skid valid bits=0, all data registers=0, InReady=1, OutValid=0, OutData=0, Occupancy=0. Reset asserted mid-transfer discards all contents; the first accepting edge is the first rising edge after deassertion.
- Transfers: accept on an edge where InValid&&InReady. Emit on an edge where OutValid&&OutReady. InValid/InData are ignored when InReady=0. OutData is held stable while OutValid=1 and OutReady=0.
- Slice i has a main register (Mv, Md) and a skid register (Sv, Sd). Its upstream ready is ~Sv. Its downstream is slice i+1, or the output ports for the last slice.
- Per-slice next state, evaluated each edge:
  - Downstream takes main and Sv=1: main<=skid; skid<=incoming if accepted, else Sv<=0.
  - Downstream takes main and Sv=0: main<=incoming if accepted, else Mv<=0.
  - Downstream does not take main: if accepted, fill main when Mv=0, otherwise fill skid.
  - Accept with Mv=1, Sv=1 is impossible because ready=0.
- Order: strict FIFO. No entry is duplicated, dropped or reordered except by Flush or reset.
- Latency: into an empty chain with OutReady=1, an entry accepted at edge k is visible on OutValid/OutData after edge k+STAGES-1, i.e. STAGES cycles after InValid is first sampled. Sustained throughput is 1 entry per cycle.
- Full: Occupancy=2*STAGES gives InReady=0 on the following cycle. InReady rises again on the edge after the first slice's skid empties. Sustained OutReady=0 fills every main and skid register.
- Flush=1 at an edge: all valid bits cleared. Flush has priority over a simultaneous accept (that InData is dropped) and over a simultaneous emit (that handshake completes upstream-side only; downstream must ignore it). After that edge: InReady=1, OutValid=0, Occupancy=0. Data registers are not cleared.
- Occupancy is the sum of all Mv and Sv bits after the edge: +1 on accept, -1 on emit, unchanged on both, 0 on Flush.

Test Plan:
- Latency (STAGES=2, OutReady=1): InValid=1 with InData=0xA5A5_0001 for one cycle -> OutValid=1 with OutData=0xA5A5_0001 exactly 2 cycles later for 1 cycle; Occupancy goes 1,1,0.
- Back-pressure (STAGES=2, OutReady=0): stream 0x1..0x6 -> 4 accepted, Occupancy=4, InReady=0. Then OutReady=1 -> outputs 0x1,0x2,0x3,0x4 on consecutive cycles; 0x5 and 0x6 are accepted once InReady=1 and follow in order.
- Streaming with random OutReady (50%) over 1000 entries: the output sequence equals the input sequence, Occupancy never exceeds 4, and no entry is lost or duplicated.
- Flush with pipeline full (Occupancy=4) plus simultaneous InValid=1, InData=0xDEAD -> next cycle Occupancy=0, OutValid=0, InReady=1; 0xDEAD never appears at the output.
- Reset mid-operation: nReset pulsed low between edges while 3 entries are held -> outputs go immediately to InReady=1, OutValid=0, OutData=0, Occupancy=0. After release, a new entry 0x7 emerges after STAGES cycles.
- Degenerate case STAGES=1, WIDTH=1: capacity 2, latency 1 cycle; alternating OutReady gives ordered output and InReady=0 only when 2 entries are held.
